// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard controller and the pipeline stage registers,
// memory handshakes and performance counters.
interface pipe_hazard_ctrl_if #(
  parameter int STAGE_NUM = 6,
  parameter int CNT_W     = 32
);
  logic [4:0]           id_rs1_addr;
  logic [4:0]           id_rs2_addr;
  logic                 id_rs1_used;
  logic                 id_rs2_used;
  logic [4:0]           ex_rd;
  logic                 ex_wreg;
  logic                 ex_memrd;
  logic                 ex_branch_taken;
  logic                 imem_req;
  logic                 imem_ready;
  logic                 dmem_req;
  logic                 dmem_ready;
  logic                 perf_clr;
  logic [STAGE_NUM-1:0] stall;
  logic                 flush;
  logic                 squash_fetch;
  logic [CNT_W-1:0]     cnt_lu;
  logic [CNT_W-1:0]     cnt_imem;
  logic [CNT_W-1:0]     cnt_dmem;
  logic [CNT_W-1:0]     cnt_flush;

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_rd, ex_wreg, ex_memrd, ex_branch_taken,
    input  imem_req, imem_ready, dmem_req, dmem_ready, perf_clr,
    output stall, flush, squash_fetch,
    output cnt_lu, cnt_imem, cnt_dmem, cnt_flush
  );

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_rd, ex_wreg, ex_memrd, ex_branch_taken,
    output imem_req, imem_ready, dmem_req, dmem_ready, perf_clr,
    input  stall, flush, squash_fetch,
    input  cnt_lu, cnt_imem, cnt_dmem, cnt_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush selection, in-flight fetch
// squashing after redirects, and per-cause performance counters.
module pipe_hazard_ctrl #(
  parameter int STAGE_NUM = 6,
  parameter int CNT_W     = 32
) (
  input logic               clk,
  input logic               rstn,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN, FETCH_WAIT} state_t;

  state_t state_reg, state_next;
  logic   squash_pending_reg, squash_pending_next;
  logic   dmem_wait, imem_wait, lu;
  logic   sel_dmem, sel_lu, sel_imem, flush_int, squash_int;

  assign dmem_wait = bus.dmem_req & ~bus.dmem_ready;
  assign imem_wait = (state_reg == FETCH_WAIT) & ~bus.imem_ready;
  assign lu = bus.ex_memrd & bus.ex_wreg & (bus.ex_rd != 5'd0) &
              ((bus.id_rs1_used & (bus.id_rs1_addr == bus.ex_rd)) |
               (bus.id_rs2_used & (bus.id_rs2_addr == bus.ex_rd)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg          <= RUN;
      squash_pending_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      squash_pending_reg <= squash_pending_next;
    end
  end

  always_comb begin
    sel_dmem            = 1'b0;
    sel_lu              = 1'b0;
    sel_imem            = 1'b0;
    flush_int           = 1'b0;
    state_next          = state_reg;
    squash_pending_next = squash_pending_reg;

    // A taken branch waiting behind a data stall is re-evaluated once MEM frees up.
    if (dmem_wait)                sel_dmem  = 1'b1;
    else if (bus.ex_branch_taken) flush_int = 1'b1;
    else if (lu)                  sel_lu    = 1'b1;
    else if (imem_wait)           sel_imem  = 1'b1;

    case (state_reg)
      RUN:        if (bus.imem_req & ~bus.imem_ready) state_next = FETCH_WAIT;
      FETCH_WAIT: if (bus.imem_ready & ~bus.imem_req) state_next = RUN;
      default:    state_next = RUN;
    endcase

    squash_int = bus.imem_ready & (squash_pending_reg | flush_int);
    if (squash_int)
      squash_pending_next = 1'b0;
    else if (flush_int & (state_reg == FETCH_WAIT))
      squash_pending_next = 1'b1;
  end

  wire [STAGE_NUM-1:0] stall_vec;
  for (genvar gi = 0; gi < STAGE_NUM; gi++) begin : g_stall
    assign stall_vec[gi] = ((gi <= 4) & sel_dmem) | ((gi <= 2) & sel_lu) |
                           ((gi <= 1) & sel_imem);
  end

  assign bus.stall        = stall_vec;
  assign bus.flush        = flush_int;
  assign bus.squash_fetch = squash_int;

  // Counter slots: 0 load-use, 1 fetch wait, 2 data wait, 3 flush.
  logic [CNT_W-1:0] cnt_reg [4];
  wire  [3:0]       cnt_inc = {flush_int, sel_dmem, sel_imem, sel_lu};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
        cnt_reg[gi] <= '0;
      else if (bus.perf_clr)
        cnt_reg[gi] <= '0;
      else if (cnt_inc[gi])
        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
    end
  end

  assign bus.cnt_lu    = cnt_reg[0];
  assign bus.cnt_imem  = cnt_reg[1];
  assign bus.cnt_dmem  = cnt_reg[2];
  assign bus.cnt_flush = cnt_reg[3];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a second narrow-counter
// instance exercises counter wrap-around.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STAGE_NUM(6), .CNT_W(32)) hz ();
  pipe_hazard_ctrl_if #(.STAGE_NUM(6), .CNT_W(4))  hs ();

  pipe_hazard_ctrl #(.STAGE_NUM(6), .CNT_W(32)) dut (.clk(clk), .rstn(rstn), .bus(hz.slave));
  pipe_hazard_ctrl #(.STAGE_NUM(6), .CNT_W(4))  dut_small (.clk(clk), .rstn(rstn), .bus(hs.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs1_addr = 0; hz.id_rs2_addr = 0; hz.id_rs1_used = 0; hz.id_rs2_used = 0;
    hz.ex_rd = 0; hz.ex_wreg = 0; hz.ex_memrd = 0; hz.ex_branch_taken = 0;
    hz.imem_req = 0; hz.imem_ready = 0; hz.dmem_req = 0; hz.dmem_ready = 0; hz.perf_clr = 0;
    hs.id_rs1_addr = 0; hs.id_rs2_addr = 0; hs.id_rs1_used = 0; hs.id_rs2_used = 0;
    hs.ex_rd = 0; hs.ex_wreg = 0; hs.ex_memrd = 0; hs.ex_branch_taken = 0;
    hs.imem_req = 0; hs.imem_ready = 0; hs.dmem_req = 0; hs.dmem_ready = 0; hs.perf_clr = 0;
  endtask

  task automatic clear_counters();
    hz.perf_clr = 1'b1;
    tick();
    hz.perf_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (hz.stall !== 6'b0) begin errors++; $display("FAIL reset_stall got %b exp %b", hz.stall, 6'b0); end
    checks++; if (hz.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", hz.flush); end
    checks++; if (hz.squash_fetch !== 1'b0) begin errors++; $display("FAIL reset_squash got %b exp 0", hz.squash_fetch); end
    checks++; if ({hz.cnt_lu, hz.cnt_imem, hz.cnt_dmem, hz.cnt_flush} !== 128'd0) begin errors++; $display("FAIL reset_counters got %0d %0d %0d %0d exp 0", hz.cnt_lu, hz.cnt_imem, hz.cnt_dmem, hz.cnt_flush); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    clear_counters();
    hz.ex_memrd = 1; hz.ex_wreg = 1; hz.ex_rd = 5;
    hz.id_rs1_addr = 5; hz.id_rs1_used = 1; hz.id_rs2_addr = 1; hz.id_rs2_used = 1;
    #1;
    checks++; if (hz.stall !== 6'b000111) begin errors++; $display("FAIL lu_stall got %b exp %b", hz.stall, 6'b000111); end
    tick();
    hz.ex_memrd = 0; hz.ex_wreg = 0; hz.ex_rd = 6;
    #1;
    checks++; if (hz.stall !== 6'b0) begin errors++; $display("FAIL lu_release got %b exp %b", hz.stall, 6'b0); end
    checks++; if (hz.cnt_lu !== 32'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", hz.cnt_lu); end
    hz.ex_memrd = 1; hz.ex_wreg = 1; hz.ex_rd = 0; hz.id_rs1_addr = 0;
    #1;
    checks++; if (hz.stall !== 6'b0) begin errors++; $display("FAIL lu_x0 got %b exp %b", hz.stall, 6'b0); end
    hz.ex_rd = 1; hz.id_rs1_used = 0;
    #1;
    checks++; if (hz.stall !== 6'b000111) begin errors++; $display("FAIL lu_rs2 got %b exp %b", hz.stall, 6'b000111); end
    tick();
    idle();
    #1;
    checks++; if (hz.cnt_lu !== 32'd2) begin errors++; $display("FAIL lu_count2 got %0d exp 2", hz.cnt_lu); end
    $display("test_load_use done");
  endtask

  task automatic test_dmem_branch();
    clear_counters();
    hz.dmem_req = 1; hz.dmem_ready = 0; hz.ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (hz.stall !== 6'b011111) begin errors++; $display("FAIL dmem_stall[%0d] got %b exp %b", i, hz.stall, 6'b011111); end
      checks++; if (hz.flush !== 1'b0) begin errors++; $display("FAIL dmem_flush[%0d] got %b exp 0", i, hz.flush); end
      tick();
    end
    hz.dmem_ready = 1;
    #1;
    checks++; if (hz.stall !== 6'b0 || hz.flush !== 1'b1) begin errors++; $display("FAIL dmem_done got stall %b flush %b exp 000000 1", hz.stall, hz.flush); end
    tick();
    idle();
    #1;
    checks++; if (hz.cnt_dmem !== 32'd3) begin errors++; $display("FAIL dmem_count got %0d exp 3", hz.cnt_dmem); end
    checks++; if (hz.cnt_flush !== 32'd1) begin errors++; $display("FAIL dmem_flushcnt got %0d exp 1", hz.cnt_flush); end
    $display("test_dmem_branch done");
  endtask

  task automatic test_fetch_wait();
    clear_counters();
    hz.imem_req = 1;
    #1;
    checks++; if (hz.stall !== 6'b0) begin errors++; $display("FAIL fw_req got %b exp %b", hz.stall, 6'b0); end
    tick();
    hz.imem_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (hz.stall !== 6'b000011) begin errors++; $display("FAIL fw_stall[%0d] got %b exp %b", i, hz.stall, 6'b000011); end
      tick();
    end
    hz.imem_ready = 1;
    #1;
    checks++; if (hz.stall !== 6'b0) begin errors++; $display("FAIL fw_ready got %b exp %b", hz.stall, 6'b0); end
    tick();
    hz.imem_ready = 0;
    #1;
    checks++; if (hz.stall !== 6'b0) begin errors++; $display("FAIL fw_run got %b exp %b", hz.stall, 6'b0); end
    checks++; if (hz.cnt_imem !== 32'd4) begin errors++; $display("FAIL fw_count got %0d exp 4", hz.cnt_imem); end
    // same-cycle request and ready stays in RUN
    hz.imem_req = 1; hz.imem_ready = 1;
    tick();
    hz.imem_req = 0; hz.imem_ready = 0;
    #1;
    checks++; if (hz.stall !== 6'b0) begin errors++; $display("FAIL fw_hit got %b exp %b", hz.stall, 6'b0); end
    $display("test_fetch_wait done");
  endtask

  task automatic test_squash();
    clear_counters();
    hz.imem_req = 1; tick(); hz.imem_req = 0;
    tick();
    hz.ex_branch_taken = 1;
    #1;
    checks++; if (hz.flush !== 1'b1 || hz.squash_fetch !== 1'b0) begin errors++; $display("FAIL sq_flush got flush %b squash %b exp 1 0", hz.flush, hz.squash_fetch); end
    tick();
    hz.ex_branch_taken = 0;
    #1;
    checks++; if (hz.squash_fetch !== 1'b0 || hz.stall !== 6'b000011) begin errors++; $display("FAIL sq_wait got squash %b stall %b exp 0 000011", hz.squash_fetch, hz.stall); end
    tick();
    hz.imem_ready = 1;
    #1;
    checks++; if (hz.squash_fetch !== 1'b1) begin errors++; $display("FAIL sq_ready got %b exp 1", hz.squash_fetch); end
    tick();
    hz.imem_ready = 0;
    #1;
    checks++; if (hz.squash_fetch !== 1'b0) begin errors++; $display("FAIL sq_after got %b exp 0", hz.squash_fetch); end
    checks++; if (hz.cnt_flush !== 32'd1) begin errors++; $display("FAIL sq_flushcnt got %0d exp 1", hz.cnt_flush); end
    // flush coincident with ready
    hz.imem_req = 1; tick(); hz.imem_req = 0;
    hz.ex_branch_taken = 1; hz.imem_ready = 1;
    #1;
    checks++; if (hz.squash_fetch !== 1'b1 || hz.flush !== 1'b1) begin errors++; $display("FAIL sq_coinc got squash %b flush %b exp 1 1", hz.squash_fetch, hz.flush); end
    tick();
    hz.ex_branch_taken = 0; hz.imem_ready = 0;
    hz.imem_req = 1; tick(); hz.imem_req = 0;
    hz.imem_ready = 1;
    #1;
    checks++; if (hz.squash_fetch !== 1'b0) begin errors++; $display("FAIL sq_no_pending got %b exp 0", hz.squash_fetch); end
    tick();
    // two flushes while waiting give a single squash
    hz.imem_ready = 0; hz.imem_req = 1; tick(); hz.imem_req = 0;
    hz.ex_branch_taken = 1; tick(); tick(); hz.ex_branch_taken = 0;
    hz.imem_ready = 1;
    #1;
    checks++; if (hz.squash_fetch !== 1'b1) begin errors++; $display("FAIL sq_double got %b exp 1", hz.squash_fetch); end
    tick();
    hz.imem_ready = 0; hz.imem_req = 1; tick(); hz.imem_req = 0;
    hz.imem_ready = 1;
    #1;
    checks++; if (hz.squash_fetch !== 1'b0) begin errors++; $display("FAIL sq_single got %b exp 0", hz.squash_fetch); end
    tick();
    idle();
    $display("test_squash done");
  endtask

  task automatic test_lu_branch();
    clear_counters();
    hz.ex_memrd = 1; hz.ex_wreg = 1; hz.ex_rd = 7; hz.id_rs2_addr = 7; hz.id_rs2_used = 1;
    hz.ex_branch_taken = 1;
    #1;
    checks++; if (hz.stall !== 6'b0 || hz.flush !== 1'b1) begin errors++; $display("FAIL lub_out got stall %b flush %b exp 000000 1", hz.stall, hz.flush); end
    tick();
    idle();
    #1;
    checks++; if (hz.cnt_lu !== 32'd0 || hz.cnt_flush !== 32'd1) begin errors++; $display("FAIL lub_cnt got lu %0d flush %0d exp 0 1", hz.cnt_lu, hz.cnt_flush); end
    $display("test_lu_branch done");
  endtask

  task automatic test_wrap();
    hs.ex_memrd = 1; hs.ex_wreg = 1; hs.ex_rd = 3; hs.id_rs1_addr = 3; hs.id_rs1_used = 1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (hs.cnt_lu !== 4'd15) begin errors++; $display("FAIL wrap_max got %0d exp 15", hs.cnt_lu); end
    tick();
    checks++; if (hs.cnt_lu !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", hs.cnt_lu); end
    tick();
    hs.perf_clr = 1;
    tick();
    hs.perf_clr = 0;
    idle();
    #1;
    checks++; if (hs.cnt_lu !== 4'd0) begin errors++; $display("FAIL clr_prio got %0d exp 0", hs.cnt_lu); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    hz.imem_req = 1; tick(); hz.imem_req = 0;
    hz.ex_branch_taken = 1; tick(); hz.ex_branch_taken = 0;
    #2;
    rstn = 0;
    #1;
    checks++; if (hz.stall !== 6'b0 || hz.flush !== 1'b0 || hz.squash_fetch !== 1'b0) begin errors++; $display("FAIL rmid_out got %b %b %b exp 000000 0 0", hz.stall, hz.flush, hz.squash_fetch); end
    checks++; if (hz.cnt_flush !== 32'd0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", hz.cnt_flush); end
    tick();
    rstn = 1;
    tick();
    #1;
    checks++; if (hz.stall !== 6'b0) begin errors++; $display("FAIL rmid_state got %b exp %b", hz.stall, 6'b0); end
    hz.imem_ready = 1;
    #1;
    checks++; if (hz.squash_fetch !== 1'b0) begin errors++; $display("FAIL rmid_pending got %b exp 0", hz.squash_fetch); end
    tick();
    idle();
    $display("test_reset_mid done");
  endtask

  initial begin
    idle();
    test_reset();
    #3 rstn = 1;
    tick();
    test_load_use();
    test_dmem_branch();
    test_fetch_wait();
    test_squash();
    test_lu_branch();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
